control_principal: RTL and testbench

Front-end control conditioner between the user push-buttons/switches and the PWM/frequency generator core. It synchronizes seven asynchronous control inputs into the system clock domain. Increment/decrement requests become single-cycle pulses. The mode and master-reset commands are forwarded as levels. Every output is gated by a master enable (`MEn`).

---
 rtl/control_principal_pkg.sv | 13 +
 rtl/control_principal_sync_edge.sv | 47 ++++
 rtl/control_principal.sv | 112 +++++++++++
 tb/tb_control_principal.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/control_principal_pkg.sv
// Shared constants for the control_principal front end: default synchronizer
// depth and bit positions of the four increment/decrement requests.
package control_principal_pkg;

   localparam int SYNC_STAGES_DEF = 2;

   localparam int NUM_REQ = 4;
   localparam int AUMF    = 0;
   localparam int BAJAF   = 1;
   localparam int AUMC    = 2;
   localparam int BAJAC   = 3;

endpackage

// File: rtl/control_principal_sync_edge.sv
// Synchronizer chain for one asynchronous input, with an optional
// previous-value flop that turns the synchronized level into a rise flag.
module sync_edge
   import control_principal_pkg::*;
#(
   parameter int STAGES   = SYNC_STAGES_DEF,
   parameter bit USE_PREV = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
      end
   end

   assign level = chain[STAGES-1];

   // Level-only inputs skip the history flop entirely.
   generate
      if (USE_PREV) begin : g_prev
         logic prev;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               prev <= 1'b0;
            end else begin
               prev <= level;
            end
         end

         assign rise = level & ~prev;
      end else begin : g_no_prev
         assign rise = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/control_principal.sv
// Conditions the user buttons/switches for the PWM core: synchronizes them,
// turns requests into gated one-cycle pulses and forwards mode/reset levels.
module control_principal
   import control_principal_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic aumf_i,
   input  logic bajaf_i,
   input  logic aumC_i,
   input  logic bajaC_i,
   input  logic MODO_i,
   input  logic MRst_i,
   input  logic MEn,
   output logic aumf_o,
   output logic bajaf_o,
   output logic aumC_o,
   output logic bajaC_o,
   output logic MODO_o,
   output logic MRst_o
);

   logic [NUM_REQ-1:0] req_in;
   logic [NUM_REQ-1:0] req_s;
   logic [NUM_REQ-1:0] req_rise;
   logic [NUM_REQ-1:0] req_opp;
   logic [NUM_REQ-1:0] req_pulse;
   logic [NUM_REQ-1:0] pulse_q;
   logic               modo_s;
   logic               mrst_s;
   logic               men_s;
   logic [2:0]         unused_rise;
   logic               modo_q;
   logic               mrst_q;

   assign req_in[AUMF]  = aumf_i;
   assign req_in[BAJAF] = bajaf_i;
   assign req_in[AUMC]  = aumC_i;
   assign req_in[BAJAC] = bajaC_i;

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
         sync_edge #(
            .STAGES   (SYNC_STAGES),
            .USE_PREV (1'b1)
         ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (req_in[i]),
            .level (req_s[i]),
            .rise  (req_rise[i])
         );
      end
   endgenerate

   sync_edge #(.STAGES(SYNC_STAGES), .USE_PREV(1'b0)) u_sync_modo (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (MODO_i),
      .level (modo_s),
      .rise  (unused_rise[0])
   );

   sync_edge #(.STAGES(SYNC_STAGES), .USE_PREV(1'b0)) u_sync_mrst (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (MRst_i),
      .level (mrst_s),
      .rise  (unused_rise[1])
   );

   // The enable goes through the same depth so gating lines up with the data.
   sync_edge #(.STAGES(SYNC_STAGES), .USE_PREV(1'b0)) u_sync_men (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (MEn),
      .level (men_s),
      .rise  (unused_rise[2])
   );

   // Each request is vetoed by its opposite partner being held at the same time.
   assign req_opp[AUMF]  = req_s[BAJAF];
   assign req_opp[BAJAF] = req_s[AUMF];
   assign req_opp[AUMC]  = req_s[BAJAC];
   assign req_opp[BAJAC] = req_s[AUMC];

   assign req_pulse = req_rise & {NUM_REQ{men_s}} & ~req_opp;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pulse_q <= '0;
         modo_q  <= 1'b0;
         mrst_q  <= 1'b0;
      end else begin
         pulse_q <= req_pulse;
         if (men_s) begin
            modo_q <= modo_s;
         end
         mrst_q  <= mrst_s & men_s;
      end
   end

   assign aumf_o  = pulse_q[AUMF];
   assign bajaf_o = pulse_q[BAJAF];
   assign aumC_o  = pulse_q[AUMC];
   assign bajaC_o = pulse_q[BAJAC];
   assign MODO_o  = modo_q;
   assign MRst_o  = mrst_q;

endmodule

// File: tb/tb_control_principal.sv
// Directed bench for control_principal: every driven cycle is queued and the
// expected outputs are rebuilt from the queued input history after each edge.
module tb_control_principal;

   logic clk = 1'b0;
   logic rst_n;
   logic aumf_i, bajaf_i, aumC_i, bajaC_i, MODO_i, MRst_i, MEn;
   logic aumf_o, bajaf_o, aumC_o, bajaC_o, MODO_o, MRst_o;

   always #5 clk = ~clk;

   control_principal #(.SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .aumf_i  (aumf_i),
      .bajaf_i (bajaf_i),
      .aumC_i  (aumC_i),
      .bajaC_i (bajaC_i),
      .MODO_i  (MODO_i),
      .MRst_i  (MRst_i),
      .MEn     (MEn),
      .aumf_o  (aumf_o),
      .bajaf_o (bajaf_o),
      .aumC_o  (aumC_o),
      .bajaC_o (bajaC_o),
      .MODO_o  (MODO_o),
      .MRst_o  (MRst_o)
   );

   // Input vector layout: {MEn, MRst, MODO, bajaC, aumC, bajaf, aumf}
   localparam logic [6:0] IDLE     = 7'b0000000;
   localparam logic [6:0] EN       = 7'b1000000;
   localparam logic [6:0] EN_AUMF  = 7'b1000001;
   localparam logic [6:0] BAJAC    = 7'b0001000;
   localparam logic [6:0] EN_BAJAC = 7'b1001000;
   localparam logic [6:0] EN_CONF  = 7'b1001100;
   localparam logic [6:0] EN_LVLS  = 7'b1110000;
   localparam logic [6:0] LVLS     = 7'b0110000;
   localparam logic [6:0] MRST     = 7'b0100000;
   localparam logic [6:0] ALL      = 7'b1111111;

   typedef struct packed {
      logic [6:0] in;
      logic       rst;
   } rec_t;

   rec_t       sb_q[$];
   int         checks = 0;
   int         passed = 0;
   logic       modo_m = 1'b0;
   int         pcnt[4];
   logic [5:0] obs;

   task automatic check(input string tag, input logic [5:0] observed, input logic [5:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, observed, expected);
   endtask

   task automatic check_cnt(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) pcnt[i] = 0;
   endtask

   // One clock cycle: drive at negedge, push the record, judge after posedge.
   task automatic applyStimulus(input logic [6:0] in, input logic rst, input string tag);
      rec_t       r;
      logic [6:0] s;
      logic [6:0] p;
      logic       men;
      logic [3:0] pul;
      logic [5:0] exp_v;
      @(negedge clk);
      {MEn, MRst_i, MODO_i, bajaC_i, aumC_i, bajaf_i, aumf_i} = in;
      rst_n = ~rst;
      r.in  = in;
      r.rst = rst;
      sb_q.push_back(r);
      if (sb_q.size() > 4) sb_q.delete(0);
      @(posedge clk);
      #1;
      obs = {MRst_o, MODO_o, bajaC_o, aumC_o, bajaf_o, aumf_o};
      if (sb_q[3].rst) begin
         exp_v  = '0;
         modo_m = 1'b0;
      end else begin
         s   = (!sb_q[2].rst && !sb_q[1].rst) ? sb_q[1].in : 7'b0;
         p   = (!sb_q[2].rst && !sb_q[1].rst && !sb_q[0].rst) ? sb_q[0].in : 7'b0;
         men = s[6];
         pul[0] = s[0] & ~p[0] & men & ~s[1];
         pul[1] = s[1] & ~p[1] & men & ~s[0];
         pul[2] = s[2] & ~p[2] & men & ~s[3];
         pul[3] = s[3] & ~p[3] & men & ~s[2];
         if (men) modo_m = s[4];
         exp_v = {s[5] & men, modo_m, pul};
      end
      for (int i = 0; i < 4; i++) pcnt[i] += int'(obs[i]);
      check(tag, obs, exp_v);
   endtask

   task automatic run(input logic [6:0] in, input logic rst, input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(in, rst, tag);
   endtask

   initial begin
      rec_t r0;
      r0.in  = '0;
      r0.rst = 1'b1;
      for (int i = 0; i < 4; i++) sb_q.push_back(r0);
      rst_n = 1'b0;
      {MEn, MRst_i, MODO_i, bajaC_i, aumC_i, bajaf_i, aumf_i} = ALL;
      clear_counts();

      run(ALL, 1'b1, 3, "reset");
      check("reset_outputs", obs, 6'b0);
      run(IDLE, 1'b0, 4, "idle");

      run(EN, 1'b0, 4, "enable");
      clear_counts();
      applyStimulus(EN_AUMF, 1'b0, "press_e0");
      applyStimulus(EN_AUMF, 1'b0, "press_e1");
      check("press_before_latency", obs, 6'b0);
      applyStimulus(EN_AUMF, 1'b0, "press_e2");
      check("press_at_latency", obs, 6'b000001);
      run(EN_AUMF, 1'b0, 7, "press_hold");
      run(EN, 1'b0, 4, "press_release");
      check_cnt("press_pulse_count", pcnt[0], 1);

      run(IDLE, 1'b0, 4, "men_off");
      clear_counts();
      run(EN_AUMF, 1'b0, 5, "men_and_req_same");
      run(IDLE, 1'b0, 4, "men_and_req_drop");
      check_cnt("same_cycle_enable_count", pcnt[0], 1);

      clear_counts();
      run(BAJAC, 1'b0, 4, "gated_press");
      run(EN_BAJAC, 1'b0, 4, "gated_men_rise");
      run(EN, 1'b0, 4, "gated_release");
      check_cnt("gated_pulse_count", pcnt[3], 0);

      clear_counts();
      run(EN_CONF, 1'b0, 6, "conflict");
      run(EN, 1'b0, 4, "conflict_release");
      check_cnt("conflict_aumC_count", pcnt[2], 0);
      check_cnt("conflict_bajaC_count", pcnt[3], 0);

      run(EN_LVLS, 1'b0, 4, "levels_on");
      check("levels_on_final", obs, 6'b110000);
      run(LVLS, 1'b0, 4, "levels_men_off");
      check("levels_men_off_final", obs, 6'b010000);
      run(MRST, 1'b0, 4, "levels_modo_low");
      check("levels_modo_hold", obs, 6'b010000);

      run(EN, 1'b0, 4, "pre_midreset");
      clear_counts();
      applyStimulus(EN_AUMF, 1'b0, "midreset_e0");
      applyStimulus(EN_AUMF, 1'b0, "midreset_e1");
      applyStimulus(EN_AUMF, 1'b1, "midreset_e2_reset");
      check("midreset_cancel", obs, 6'b0);
      run(EN_AUMF, 1'b0, 8, "midreset_refill");
      run(EN, 1'b0, 4, "midreset_release");
      check_cnt("midreset_pulse_count", pcnt[0], 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
